pattern_sequencer: RTL and testbench

- Controller for the test pattern generator.
- Watches the raster counters and decides which pattern is shown.
- Advances the pattern automatically every `HOLD_FRAMES` frames, or holds a manually configured pattern.
- Pattern changes take effect only at frame boundaries, so a frame is never torn.
- Sits between the video timing counter and the pattern generator, and also emits a data-enable aligned to the generator's one-cycle output latency.

---
 rtl/video_pkg.sv | 31 +++
 rtl/frame_hold_counter.sv | 38 +++
 rtl/pattern_sequencer.sv | 123 ++++++++++++
 tb/tb_pattern_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | video_pkg: shared raster timing defaults, pattern and sequencer types |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package video_pkg;

  localparam int c_h_total  = 800;
  localparam int c_v_total  = 600;
  localparam int c_h_active = 640;
  localparam int c_v_active = 480;

  typedef enum logic [1:0] {
    PAT_SMPTE     = 2'd0,
    PAT_GRAY16    = 2'd1,
    PAT_PRIMARIES = 2'd2,
    PAT_SPECTRUM  = 2'd3
  } pattern_e;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    PEND = 1'b1
  } seq_state_e;

  // Index width that never collapses to zero bits for tiny counts.
  function automatic int clog2_min1(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_hold_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_hold_counter: counts frame boundaries, pulses on the last one  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module frame_hold_counter
  import video_pkg::*;
#(
  parameter int HOLD_FRAMES = 120
) (
  input  logic clk,
  input  logic rst,
  input  logic i_bnd,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_wrap
);

  localparam int              c_cw   = clog2_min1(HOLD_FRAMES);
  localparam logic [c_cw-1:0] c_last = c_cw'(HOLD_FRAMES - 1);

  logic [c_cw-1:0] r_cnt;

  // A clear on the same boundary suppresses the wrap, so an apply wins.
  assign o_wrap = i_bnd && i_enable && !i_clear && (r_cnt == c_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_bnd && i_enable) begin
      r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pattern_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pattern_sequencer: selects the test pattern, switching only at frame  |
// | boundaries, and emits a data-enable aligned to the generator latency  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pattern_sequencer
  import video_pkg::*;
#(
  parameter  int HMAX         = c_h_total,
  parameter  int VMAX         = c_v_total,
  parameter  int HA           = c_h_active,
  parameter  int VA           = c_v_active,
  parameter  int NUM_PATTERNS = 4,
  parameter  int HOLD_FRAMES  = 120,
  localparam int PW           = clog2_min1(NUM_PATTERNS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [$clog2(HMAX)-1:0] i_hcount,
  input  logic [$clog2(VMAX)-1:0] i_vcount,
  input  logic                    i_cfg_valid,
  output logic                    o_cfg_ready,
  input  logic                    i_cfg_auto,
  input  logic [PW-1:0]           i_cfg_pattern,
  output logic [PW-1:0]           o_pattern_sel,
  output logic                    o_auto,
  output logic                    o_frame_start,
  output logic                    o_de
);

  localparam int               c_hcw      = $clog2(HMAX);
  localparam int               c_vcw      = $clog2(VMAX);
  localparam logic [c_hcw-1:0] c_hlast    = c_hcw'(HMAX - 1);
  localparam logic [c_vcw-1:0] c_vlast    = c_vcw'(VMAX - 1);
  localparam logic [c_hcw-1:0] c_ha       = c_hcw'(HA);
  localparam logic [c_vcw-1:0] c_va       = c_vcw'(VA);
  localparam logic [PW-1:0]    c_pat_last = PW'(NUM_PATTERNS - 1);

  seq_state_e      r_state;
  seq_state_e      w_state_nxt;
  logic            r_cfg_auto;
  logic [PW-1:0]   r_cfg_pat;
  logic [PW-1:0]   r_sel;
  logic            r_auto;
  logic            r_frame_start;
  logic            r_de;
  logic            w_bnd;
  logic            w_hs;
  logic            w_apply;
  logic            w_wrap;
  logic [PW-1:0]   w_apply_pat;

  assign w_bnd       = (i_hcount == c_hlast) && (i_vcount == c_vlast);
  assign o_cfg_ready = (r_state == RUN) && !rst;
  assign w_hs        = i_cfg_valid && o_cfg_ready;
  assign w_apply     = (r_state == PEND) && w_bnd;
  // Out-of-range indices are accepted but fall back to pattern 0.
  assign w_apply_pat = (int'(r_cfg_pat) < NUM_PATTERNS) ? r_cfg_pat : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (w_hs)  w_state_nxt = PEND;
      PEND:    if (w_bnd) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg_auto <= 1'b1;
      r_cfg_pat  <= '0;
    end else if (w_hs) begin
      r_cfg_auto <= i_cfg_auto;
      r_cfg_pat  <= i_cfg_pattern;
    end
  end

  frame_hold_counter #(
    .HOLD_FRAMES (HOLD_FRAMES)
  ) u_hold (
    .clk      (clk),
    .rst      (rst),
    .i_bnd    (w_bnd),
    .i_clear  (w_apply || !r_auto),
    .i_enable (r_auto),
    .o_wrap   (w_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel         <= '0;
      r_auto        <= 1'b1;
      r_frame_start <= 1'b0;
      r_de          <= 1'b0;
    end else begin
      r_frame_start <= w_bnd;
      r_de          <= (i_hcount < c_ha) && (i_vcount < c_va);
      if (w_apply) begin
        r_sel  <= w_apply_pat;
        r_auto <= r_cfg_auto;
      end else if (w_wrap) begin
        r_sel <= (r_sel == c_pat_last) ? '0 : r_sel + 1'b1;
      end
    end
  end

  assign o_pattern_sel = r_sel;
  assign o_auto        = r_auto;
  assign o_frame_start = r_frame_start;
  assign o_de          = r_de;

endmodule
`default_nettype wire

// File: tb/tb_pattern_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pattern_sequencer: scoreboard bench for two sequencer instances   |
// | (4 and 5 patterns) sharing one raster and configuration stream       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pattern_sequencer;
  import video_pkg::*;

  localparam int HMAX  = 10;
  localparam int VMAX  = 8;
  localparam int HA    = 6;
  localparam int VA    = 4;
  localparam int HOLD  = 2;
  localparam int FRAME = HMAX * VMAX;
  localparam int HCW   = $clog2(HMAX);
  localparam int VCW   = $clog2(VMAX);

  typedef struct packed {
    logic       pend;
    logic       cauto;
    logic [2:0] cpat;
    logic [2:0] sel;
    logic       aut;
    logic [7:0] hold;
    logic       fs;
    logic       de;
  } mstate_t;

  logic           clk         = 1'b0;
  logic           rst         = 1'b1;
  logic [HCW-1:0] hcount      = '0;
  logic [VCW-1:0] vcount      = '0;
  logic           cfg_valid   = 1'b0;
  logic           cfg_auto    = 1'b0;
  logic [2:0]     cfg_pattern = '0;

  logic       ready4, auto4, fs4, de4;
  logic [1:0] sel4;
  logic       ready5, auto5, fs5, de5;
  logic [2:0] sel5;

  int      n_checks = 0;
  int      n_fail   = 0;
  mstate_t m4, m5;
  logic [5:0] exp_q4[$];
  logic [5:0] exp_q5[$];

  always #5 clk = ~clk;

  pattern_sequencer #(
    .HMAX(HMAX), .VMAX(VMAX), .HA(HA), .VA(VA), .NUM_PATTERNS(4), .HOLD_FRAMES(HOLD)
  ) u_dut4 (
    .clk(clk), .rst(rst), .i_hcount(hcount), .i_vcount(vcount),
    .i_cfg_valid(cfg_valid), .o_cfg_ready(ready4), .i_cfg_auto(cfg_auto),
    .i_cfg_pattern(cfg_pattern[1:0]), .o_pattern_sel(sel4), .o_auto(auto4),
    .o_frame_start(fs4), .o_de(de4)
  );

  pattern_sequencer #(
    .HMAX(HMAX), .VMAX(VMAX), .HA(HA), .VA(VA), .NUM_PATTERNS(5), .HOLD_FRAMES(HOLD)
  ) u_dut5 (
    .clk(clk), .rst(rst), .i_hcount(hcount), .i_vcount(vcount),
    .i_cfg_valid(cfg_valid), .o_cfg_ready(ready5), .i_cfg_auto(cfg_auto),
    .i_cfg_pattern(cfg_pattern), .o_pattern_sel(sel5), .o_auto(auto5),
    .o_frame_start(fs5), .o_de(de5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic mstate_t mreset();
    mstate_t s;
    s     = '0;
    s.aut = 1'b1;
    return s;
  endfunction

  // Reference behaviour for one clock edge given the inputs seen at that edge.
  function automatic mstate_t mstep(input mstate_t s, input bit r, input int h, input int v,
                                    input bit valid, input bit au, input int pat, input int num);
    mstate_t n;
    bit      bnd;
    if (r) return mreset();
    n    = s;
    bnd  = (h == HMAX - 1) && (v == VMAX - 1);
    n.fs = bnd;
    n.de = (h < HA) && (v < VA);
    if (s.pend && bnd) begin
      n.pend = 1'b0;
      n.sel  = (int'(s.cpat) < num) ? s.cpat : 3'd0;
      n.aut  = s.cauto;
      n.hold = '0;
    end else begin
      if (!s.aut) begin
        n.hold = '0;
      end else if (bnd) begin
        if (s.hold == 8'(HOLD - 1)) begin
          n.sel  = 3'((int'(s.sel) + 1) % num);
          n.hold = '0;
        end else begin
          n.hold = s.hold + 8'd1;
        end
      end
      if (!s.pend && valid) begin
        n.pend  = 1'b1;
        n.cauto = au;
        n.cpat  = 3'(pat);
      end
    end
    return n;
  endfunction

  function automatic logic [5:0] outs(input mstate_t s);
    return {s.sel, s.aut, s.fs, s.de};
  endfunction

  task automatic tick();
    mstate_t    n4, n5;
    logic [5:0] e4, e5;
    n4 = mstep(m4, rst, int'(hcount), int'(vcount), cfg_valid, cfg_auto, int'(cfg_pattern) & 3, 4);
    n5 = mstep(m5, rst, int'(hcount), int'(vcount), cfg_valid, cfg_auto, int'(cfg_pattern), 5);
    exp_q4.push_back(outs(n4));
    exp_q5.push_back(outs(n5));
    @(posedge clk);
    #1;
    m4 = n4;
    m5 = n5;
    e4 = exp_q4.pop_front();
    e5 = exp_q5.pop_front();
    check("dut4_outs", 32'({1'b0, sel4, auto4, fs4, de4}), 32'(e4));
    check("dut5_outs", 32'({sel5, auto5, fs5, de5}), 32'(e5));
    check("dut4_ready", 32'(ready4), 32'(!m4.pend && !rst));
    check("dut5_ready", 32'(ready5), 32'(!m5.pend && !rst));
    if (int'(hcount) == HMAX - 1) begin
      hcount = '0;
      vcount = (int'(vcount) == VMAX - 1) ? '0 : VCW'(int'(vcount) + 1);
    end else begin
      hcount = HCW'(int'(hcount) + 1);
    end
  endtask

  task automatic run_until(input int h, input int v);
    int n;
    n = 0;
    while (!(int'(hcount) == h && int'(vcount) == v) && n <= FRAME) begin
      tick();
      n++;
    end
    if (n > FRAME) check("run_until_timeout", 32'(n), 32'd0);
  endtask

  task automatic send(input bit au, input int pat);
    cfg_valid   = 1'b1;
    cfg_auto    = au;
    cfg_pattern = 3'(pat);
    tick();
    cfg_valid   = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    m4 = mreset();
    m5 = mreset();
    repeat (3) tick();
    check("rst_sel",   32'(sel4),   32'd0);
    check("rst_auto",  32'(auto4),  32'd1);
    check("rst_fs",    32'(fs4),    32'd0);
    check("rst_de",    32'(de4),    32'd0);
    check("rst_ready", 32'(ready4), 32'd0);

    // Auto cycling from release with the raster starting at (0,0).
    rst    = 1'b0;
    hcount = '0;
    vcount = '0;
    #1;
    check("ready_after_rst", 32'(ready4), 32'd1);
    repeat (2 * FRAME) tick();
    check("t1_sel_frame3", 32'(sel4), 32'd1);
    check("t1_fs_frame3",  32'(fs4),  32'd1);
    repeat (12 * FRAME) tick();
    check("t1_sel_frame15", 32'(sel4), 32'd3);
    repeat (2 * FRAME) tick();
    check("t1_wrap", 32'(sel4), 32'd0);

    // Manual config handshaked mid-frame.
    run_until(3, 2);
    send(1'b0, 2);
    check("t2_ready_low", 32'(ready4), 32'd0);
    run_until(9, 7);
    check("t2_ready_low_bnd", 32'(ready4), 32'd0);
    run_until(0, 0);
    check("t2_sel",   32'(sel4),   32'd2);
    check("t2_auto",  32'(auto4),  32'd0);
    check("t2_ready", 32'(ready4), 32'd1);
    repeat (3 * FRAME) tick();
    check("t2_frozen", 32'(sel4), 32'd2);

    // Handshake on the boundary cycle waits a whole frame.
    run_until(9, 7);
    send(1'b1, 3);
    check("t3_not_applied", 32'(sel4),   32'd2);
    check("t3_pending",     32'(ready4), 32'd0);
    repeat (FRAME) tick();
    check("t3_applied", 32'(sel4),  32'd3);
    check("t3_auto",    32'(auto4), 32'd1);

    // Apply on the same boundary as an auto wrap.
    repeat (FRAME) tick();
    check("t4_pre", 32'(sel4), 32'd3);
    run_until(3, 2);
    send(1'b1, 1);
    run_until(0, 0);
    check("t4_apply_wins", 32'(sel4), 32'd1);
    repeat (FRAME) tick();
    check("t4_hold_restart", 32'(sel4), 32'd1);
    repeat (FRAME) tick();
    check("t4_next_advance", 32'(sel4), 32'd2);

    // Out-of-range index on the 5-pattern instance.
    run_until(3, 2);
    send(1'b0, 5);
    run_until(0, 0);
    check("t5_sel5_oor",  32'(sel5),  32'd0);
    check("t5_auto5",     32'(auto5), 32'd0);
    check("t5_sel4_trunc", 32'(sel4), 32'd1);

    // Data enable edges.
    run_until(5, 3);
    tick();
    check("t6_de_in",   32'(de4), 32'd1);
    tick();
    check("t6_de_h_out", 32'(de4), 32'd0);
    run_until(5, 4);
    tick();
    check("t6_de_v_out", 32'(de4), 32'd0);

    // Reset while a config is pending.
    cfg_valid = 1'b0;
    run_until(3, 2);
    send(1'b1, 2);
    check("t6_pending", 32'(ready4), 32'd0);
    rst = 1'b1;
    repeat (2) tick();
    check("t6_rst_sel",   32'(sel4),   32'd0);
    check("t6_rst_auto",  32'(auto4),  32'd1);
    check("t6_rst_ready", 32'(ready4), 32'd0);
    rst = 1'b0;
    #1;
    check("t6_ready_release", 32'(ready4), 32'd1);
    repeat (FRAME) tick();
    check("t6_dropped_sel",  32'(sel4),  32'd0);
    check("t6_dropped_auto", 32'(auto4), 32'd1);
    repeat (FRAME) tick();
    check("t6_resume", 32'(sel4), 32'd1);

    check("sb_empty4", 32'(exp_q4.size()), 32'd0);
    check("sb_empty5", 32'(exp_q5.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
